// File: rtl/regfile_we_scoreboard.sv
// Register-file write-enable generator with a pending-write scoreboard.
// Fixed-priority writeback arbitration, one-hot we, per-register busy bits and hazard flags.
module regfile_we_scoreboard #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_WR-1:0]                      wr_valid,
   input  logic [NUM_WR*ADDR_W-1:0]               wr_addr,
   input  logic                                   issue_valid,
   input  logic [ADDR_W-1:0]                      issue_addr,
   input  logic [ADDR_W-1:0]                      src_a_addr,
   input  logic [ADDR_W-1:0]                      src_b_addr,
   output logic [(2**ADDR_W)-1:0]                 we,
   output logic [((NUM_WR > 1) ? $clog2(NUM_WR) : 1)-1:0] we_port,
   output logic [(2**ADDR_W)-1:0]                 busy,
   output logic                                   src_a_busy,
   output logic                                   src_b_busy,
   output logic                                   collision
);

   localparam int unsigned NUM_REGS = 2**ADDR_W;
   localparam int unsigned PORT_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam logic [NUM_REGS-1:0] ZERO_MASK = NUM_REGS'(1) << ZERO_REG;

   logic [ADDR_W-1:0]   w_port_addr [NUM_WR];
   logic [NUM_WR-1:0]   w_port_req;
   logic                w_win_valid;
   logic [PORT_W-1:0]   w_win_port;
   logic [ADDR_W-1:0]   w_win_addr;
   logic                w_drop;
   logic [NUM_REGS-1:0] w_win_onehot;
   logic [NUM_REGS-1:0] w_issue_onehot;
   logic [NUM_REGS-1:0] w_busy_next;

   logic [NUM_REGS-1:0] r_we;
   logic [PORT_W-1:0]   r_we_port;
   logic [NUM_REGS-1:0] r_busy;
   logic                r_collision;

   // Unpack ports; requests to the hardwired zero register are not requests at all.
   for (genvar p = 0; p < NUM_WR; p++) begin : g_port
      assign w_port_addr[p] = wr_addr[p*ADDR_W +: ADDR_W];
      assign w_port_req[p]  = wr_valid[p] && (w_port_addr[p] != ADDR_W'(ZERO_REG));
   end

   // Lowest-numbered requesting port wins; any further request is dropped.
   always_comb begin
      w_win_valid = 1'b0;
      w_win_port  = '0;
      w_win_addr  = '0;
      w_drop      = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (w_port_req[p]) begin
            if (w_win_valid) begin
               w_drop = 1'b1;
            end else begin
               w_win_valid = 1'b1;
               w_win_port  = PORT_W'(p);
               w_win_addr  = w_port_addr[p];
            end
         end
      end
   end

   assign w_win_onehot   = w_win_valid ? (NUM_REGS'(1) << w_win_addr) : '0;
   assign w_issue_onehot = issue_valid ? (NUM_REGS'(1) << issue_addr) : '0;

   // Issue beats a same-cycle writeback: the new pending write owns the register.
   assign w_busy_next = ((r_busy & ~w_win_onehot) | w_issue_onehot) & ~ZERO_MASK;

   // A register being written back this cycle is already forwardable.
   assign src_a_busy = r_busy[src_a_addr] && !(w_win_valid && (w_win_addr == src_a_addr));
   assign src_b_busy = r_busy[src_b_addr] && !(w_win_valid && (w_win_addr == src_b_addr));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_we        <= '0;
         r_we_port   <= '0;
         r_busy      <= '0;
         r_collision <= 1'b0;
      end else begin
         r_we        <= w_win_onehot & ~ZERO_MASK;
         r_we_port   <= w_win_port;
         r_busy      <= w_busy_next;
         r_collision <= w_drop;
      end
   end

   assign we        = r_we;
   assign we_port   = r_we_port;
   assign busy      = r_busy;
   assign collision = r_collision;

endmodule

// File: doc/regfile_we_scoreboard.md
# regfile_we_scoreboard

Parametrised register-file write-enable generator with a pending-write scoreboard. It sits between the writeback stage and the register file and accepts up to NUM_WR writeback requests per cycle. Each request is decoded into a registered one-hot write-enable vector. A busy bit per register is tracked from issue until writeback, and the busy state of two source operands is reported to the issue/hazard logic. The hardwired zero register (ZERO_REG) is never written and never busy.

## Interface
Parameters:
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W (derived, not overridable)
- NUM_WR, 2, number of writeback ports (1..4)
- ZERO_REG, 31, index of the hardwired zero register; write enable and busy bit forced to 0

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_valid  in  NUM_WR  per-port writeback request
- wr_addr  in  NUM_WR*ADDR_W  per-port destination; port p occupies bits [p*ADDR_W +: ADDR_W]
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_addr  in  ADDR_W  destination register of the issuing instruction
- src_a_addr, src_b_addr  in  ADDR_W each  source operands to check
- we  out  NUM_REGS  registered write enables to the register file, at most one bit set
- we_port  out  clog2(NUM_WR) (min 1)  registered index of the winning port, used for data-mux select
- busy  out  NUM_REGS  registered scoreboard
- src_a_busy, src_b_busy  out  1  combinational hazard flags
- collision  out  1  registered; set for one cycle when a request was dropped

## Operation
- Decode: each valid port p produces a one-hot vector onehot_p = (1 << wr_addr_p). If wr_addr_p == ZERO_REG, the vector is all zeros.
- Arbitration: the lowest-numbered valid port with a non-zero-register address wins. All other valid non-zero-register requests are dropped.
  - collision is set next cycle if any request was dropped.
  - Requests to ZERO_REG are discarded silently and never count as a collision.
- Write enables:
  - we <= onehot of the winner, or all zeros if there is no winner.
  - we_port <= the winner's index, or 0 if there is no winner.
- Scoreboard, per register r != ZERO_REG, next-state priority:
  1. Reset forces busy to 0.
  2. issue_valid && issue_addr == r sets busy[r] to 1. This holds even if r is written back the same cycle, because the new pending write wins.
  3. The winning writeback to r clears busy[r] to 0.
  4. Otherwise busy[r] holds.
  - busy[ZERO_REG] is constant 0.
- Re-issue to an already-busy register keeps the bit at 1. The bit is not counted, so the first writeback clears it.
- Writeback to a non-busy register is legal: we is asserted and busy stays 0.
- Hazard flags: src_x_busy = busy[src_x_addr] && !(a winning writeback to src_x_addr this cycle). This gives writeback-to-read forwarding visibility in the same cycle. Both flags are 0 for ZERO_REG.

## Timing
- Reset values, after a rising edge with reset_n == 0: we = 0, we_port = 0, busy = 0, collision = 0.
- Reset dominates every other input that cycle. An issue or writeback presented during reset is lost.
- Latency:
  - wr_valid/wr_addr to we/we_port: 1 cycle.
  - issue to busy: 1 cycle.
  - writeback to busy clear: 1 cycle, the same edge on which we asserts.
- src_a_busy/src_b_busy are purely combinational from the current busy, src addresses and writeback inputs, with zero latency.
- we is a single-cycle pulse per request. Back-to-back requests to the same register give consecutive one-cycle pulses.
- There is no backpressure. Dropped requests are not retried; the upstream logic must avoid collisions, and collision is a diagnostic only.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles while driving wr_valid = 2'b11 and issue_valid = 1 -> we = 0, busy = 0, collision = 0 after each edge.
- Decode sweep (NUM_WR = 1): wr_addr = 0..31 with wr_valid = 1 -> next cycle we == 1 << addr for addr 0..30; addr 31 -> we = 0, collision = 0.
- Arbitration: port0 = 5 and port1 = 9 both valid -> we = 32'h0000_0020, we_port = 0, collision = 1 for one cycle. Then port0 = 31, port1 = 9 -> we = 32'h0000_0200, we_port = 1, collision = 0.
- Scoreboard lifecycle:
  - Issue r7 -> busy[7] = 1; src_a_addr = 7 -> src_a_busy = 1.
  - Writeback r7 on port1 -> src_a_busy = 0 in that same cycle; busy[7] = 0 next cycle.
- Simultaneous issue and writeback of r12 with busy[12] = 1 -> we[12] pulses and busy[12] stays 1. A further writeback clears it.
- Zero register: issue r31 with src_b_addr = 31 -> busy[31] = 0, src_b_busy = 0, we[31] never asserted.
